// File: rtl/snake_pkg.sv
// Shared definitions for the game modules: seven-segment codes, game status
// encodings and the BCD converter state type.
package snake_pkg;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}; the decimal point stays off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    LAUNCHING    = 2'd0,
    PLAYING      = 2'd1,
    DIE_FLASHING = 2'd2,
    INITIALIZING = 2'd3
  } game_status_t;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  // Nibbles above 9 only appear through a converter fault; show them blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 14-bit binary to four BCD digits.
// One bit per cycle, MSB first; bin must stay stable until done.
module bin2bcd_seq
  import snake_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  conv_state_t state, state_nxt;
  logic [3:0]  step;
  logic [3:0]  bit_sel;
  logic [15:0] bcd_adj;

  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign bcd_adj = add3(bcd);
  assign bit_sel = 4'd13 - step;
  assign done    = (state == CONV_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:  if (start) state_nxt = CONV_SHIFT;
      CONV_SHIFT: if (step == 4'd13) state_nxt = CONV_DONE;
      CONV_DONE:  state_nxt = CONV_IDLE;
      default:    state_nxt = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= CONV_IDLE;
      step  <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CONV_IDLE && start) begin
        step <= '0;
        bcd  <= '0;
      end else if (state == CONV_SHIFT) begin
        step <= step + 4'd1;
        bcd  <= {bcd_adj[14:0], bin[bit_sel]};
      end
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed seven-segment driver: score on digits 0-3,
// elapsed time on digits 4-7, each clamped and converted to BCD once per frame.
module seg_scan_display
  import snake_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int FIELD_MAX = 9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] score,
  input  logic [31:0] total_time,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int              PW          = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [31:0]     FIELD_MAX_U = 32'(FIELD_MAX);
  localparam logic [13:0]     FIELD_SAT   = 14'(FIELD_MAX);

  function automatic logic [13:0] clamp(input logic [31:0] v);
    return (v > FIELD_MAX_U) ? FIELD_SAT : v[13:0];
  endfunction

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          started;
  logic          frame_start;
  logic [13:0]   snap_score, snap_time;
  logic [15:0]   bcd_score, bcd_time;
  logic          done_score, done_time;
  logic [15:0]   disp_score, disp_time;
  logic [15:0]   field;
  logic [1:0]    pos;
  logic [3:0]    digit;
  logic          blank;
  logic [7:0]    seg_nxt;

  // A conversion kicks off on the 7->0 wrap, and once straight out of reset.
  assign frame_start = !started || (idx == 3'd7 && presc == PRESC_LAST);

  bin2bcd_seq u_conv_score (
    .clock (clock),
    .reset (reset),
    .start (frame_start),
    .bin   (snap_score),
    .bcd   (bcd_score),
    .done  (done_score)
  );

  bin2bcd_seq u_conv_time (
    .clock (clock),
    .reset (reset),
    .start (frame_start),
    .bin   (snap_time),
    .bcd   (bcd_time),
    .done  (done_time)
  );

  always_comb begin
    pos   = idx[1:0];
    field = idx[2] ? disp_time : disp_score;
    digit = field[{pos, 2'b00} +: 4];
    blank = 1'b0;
    case (pos)
      2'd3:    blank = (field[15:12] == 4'd0);
      2'd2:    blank = (field[15:8]  == 8'd0);
      2'd1:    blank = (field[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    seg_nxt = blank ? SEG_BLANK : seg_decode(digit);
  end

  // an/seg register the current index together, so both switch on one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      idx        <= '0;
      started    <= 1'b0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
      snap_score <= '0;
      snap_time  <= '0;
      disp_score <= '0;
      disp_time  <= '0;
    end else begin
      started <= 1'b1;
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      an  <= ~(8'd1 << idx);
      seg <= seg_nxt;
      if (frame_start) begin
        snap_score <= clamp(score);
        snap_time  <= clamp(total_time);
      end
      if (done_score) disp_score <= bcd_score;
      if (done_time)  disp_time  <= bcd_time;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with SCAN_DIV = 16: fixed vectors, random values
// against a decimal reference model, and timed reset/snapshot sequences.
module tb_seg_scan_display;

  localparam int SCAN_DIV = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] score = '0;
  logic [31:0] total_time = '0;
  logic [7:0]  an;
  logic [7:0]  seg;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0]     score;
    logic [31:0]     ttime;
    logic [7:0][7:0] exp;   // exp[d] = seg expected on digit d
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] seg_tab [10];

  seg_scan_display #(.SCAN_DIV(SCAN_DIV), .FIELD_MAX(9999)) dut (
    .clock      (clock),
    .reset      (reset),
    .score      (score),
    .total_time (total_time),
    .an         (an),
    .seg        (seg)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: an/seg got %h required %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns at the negedge right after an first shows FE of a new frame.
  task automatic wait_fe(input string name);
    logic [7:0] prev;
    bit found;
    found = 1'b0;
    prev  = an;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (an == 8'hFE && prev != 8'hFE) found = 1'b1;
      prev = an;
    end
    if (!found) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: no frame start, an got %h required fe", name, an);
    end
  endtask

  // Decimal reference: clamp, take digit k, blank leading zeros above units.
  function automatic logic [7:0] model_seg(input logic [31:0] val, input int k);
    int v, p;
    v = (val > 32'd9999) ? 9999 : int'(val);
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 8'hFF;
    return seg_tab[(v / p) % 10];
  endfunction

  // Applies values, lets two frames pass, then checks the last cycle of every slot.
  task automatic show_and_check(input string name, input logic [31:0] s,
                                input logic [31:0] t, input logic [7:0][7:0] exp);
    score      = s;
    total_time = t;
    wait_fe(name);
    wait_fe(name);
    tick(SCAN_DIV - 1);
    for (int d = 0; d < 8; d++) begin
      if (d > 0) tick(SCAN_DIV);
      check(name, {an, seg}, {~(8'h01 << d), exp[d]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][7:0] e;
    logic [31:0] rs, rt;

    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    vecs[0] = '{32'd0,     32'd0,        {8'hFF,8'hFF,8'hFF,8'hC0,8'hFF,8'hFF,8'hFF,8'hC0}};
    vecs[1] = '{32'd1234,  32'd56,       {8'hFF,8'hFF,8'h92,8'h82,8'hF9,8'hA4,8'hB0,8'h99}};
    vecs[2] = '{32'd12345, 32'hFFFFFFFF, {8{8'h90}}};
    vecs[3] = '{32'd1000,  32'd9,        {8'hFF,8'hFF,8'hFF,8'h90,8'hF9,8'hC0,8'hC0,8'hC0}};
    vecs[4] = '{32'd9999,  32'd10000,    {8{8'h90}}};
    vecs[5] = '{32'd10,    32'd100,      {8'hFF,8'hF9,8'hC0,8'hC0,8'hFF,8'hFF,8'hF9,8'hC0}};

    // Reset held, then the first frame and wrap with zero inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("reset_hold", {an, seg}, 16'hFFFF);
    end
    reset = 1'b1;
    for (int c = 0; c < 9 * SCAN_DIV; c++) begin
      @(negedge clock);
      check("first_frame", {an, seg},
            {~(8'h01 << ((c / SCAN_DIV) % 8)),
             (((c / SCAN_DIV) % 8) == 0 || ((c / SCAN_DIV) % 8) == 4) ? 8'hC0 : 8'hFF});
    end

    for (int i = 0; i < 6; i++)
      show_and_check("table", vecs[i].score, vecs[i].ttime, vecs[i].exp);

    for (int r = 0; r < 8; r++) begin
      rs = (r == 3) ? $urandom() : $urandom_range(0, 12000);
      rt = (r == 5) ? $urandom() : $urandom_range(0, 10999);
      for (int d = 0; d < 8; d++) e[d] = model_seg((d < 4) ? rs : rt, d % 4);
      show_and_check("random", rs, rt, e);
    end

    // A change five cycles into a frame waits for the next frame's conversion.
    show_and_check("snap_pre", 32'd7, 32'd0, {8'hFF,8'hFF,8'hFF,8'hC0,8'hFF,8'hFF,8'hFF,8'hF8});
    wait_fe("snap");
    tick(4);
    score = 32'd8;
    tick(10);
    check("snap_same_e15", {an, seg}, {8'hFE, 8'hF8});
    tick(1);
    check("snap_same_e16", {an, seg}, {8'hFE, 8'hF8});
    wait_fe("snap");
    tick(14);
    check("snap_next_e15", {an, seg}, {8'hFE, 8'hF8});
    tick(1);
    check("snap_next_e16", {an, seg}, {8'hFE, 8'h80});

    // Reset asserted mid-conversion: immediate blank, then a fresh conversion.
    score = 32'd55;
    wait_fe("rst_mid");
    tick(3);
    reset = 1'b0;
    #1;
    check("rst_async", {an, seg}, 16'hFFFF);
    tick(2);
    check("rst_held", {an, seg}, 16'hFFFF);
    reset = 1'b1;
    for (int c = 0; c < 17; c++) begin
      tick(1);
      if (c < 16) check("rst_restart", {an, seg}, {8'hFE, 8'hC0});
      else        check("rst_result",  {an, seg}, {8'hFD, 8'h92});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
